// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write arbiter.
package fifo_arb_pkg;

  localparam int ARB_MAX_REQ   = 16;
  localparam int ARB_MAX_BURST = 256;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Index width for n requesters; never narrower than one bit.
  function automatic int arb_id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin picker: rotate the request vector so start_idx sits at bit 0,
// take the first set bit, then rotate the winner back to an absolute index.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = arb_id_w(N)
) (
  input  logic [N-1:0]  req_vec,
  input  logic [IW-1:0] start_idx,
  output logic          found,
  output logic [IW-1:0] win_idx
);

  logic [N-1:0] rot;
  logic [IW:0]  off;
  logic [IW:0]  sum;

  // Rotate, priority-encode from bit 0, and map the offset back modulo N.
  always_comb begin
    rot   = N'({req_vec, req_vec} >> start_idx);
    found = |rot;
    off   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) off = (IW+1)'(k);
    end
    sum = {1'b0, start_idx} + off;
    if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
    win_idx = sum[IW-1:0];
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one FIFO write port among NUM_REQ
// valid/ready producers. Define FIFO_ARB_BURST_LOCK_EN to let a producer keep
// the grant for up to BURST_LEN consecutive beats; otherwise every transfer
// releases the grant (one beat per grant).
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 4,
  localparam int ID_W      = arb_id_w(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  output logic                          grant_vld,
  output logic [ID_W-1:0]               grant_id
);

  if (NUM_REQ < 2 || NUM_REQ > ARB_MAX_REQ) begin : g_bad_num_req
    $error("fifo_wr_arbiter: NUM_REQ out of range");
  end
  if (BURST_LEN < 1 || BURST_LEN > ARB_MAX_BURST) begin : g_bad_burst_len
    $error("fifo_wr_arbiter: BURST_LEN out of range");
  end

  arb_state_t      state_q, state_d;
  logic [ID_W-1:0] grant_id_q, grant_id_d;
  logic [ID_W-1:0] last_grant_q, last_grant_d;

`ifdef FIFO_ARB_BURST_LOCK_EN
  localparam int BC_W = $clog2(BURST_LEN + 1);
  logic [BC_W-1:0] beat_cnt_q, beat_cnt_d;
`endif

  logic            cur_valid;
  logic            xfer;
  logic            at_limit;
  logic            release_g;
  logic [ID_W-1:0] start_idx;
  logic            pick_found;
  logic [ID_W-1:0] pick_idx;

  // Search begins just past the last winner, so the releasing producer comes last.
  assign start_idx = (last_grant_q == ID_W'(NUM_REQ - 1)) ? '0 : last_grant_q + 1'b1;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_pick (
    .req_vec   (req_valid),
    .start_idx (start_idx),
    .found     (pick_found),
    .win_idx   (pick_idx)
  );

  // Zero-latency write path: ready, write strobe and data mux, all gated by full.
  always_comb begin
    grant_vld    = (state_q == GRANT);
    grant_id     = grant_id_q;
    cur_valid    = req_valid[grant_id_q];
    fifo_wr_en   = grant_vld & cur_valid & ~fifo_full;
    fifo_wr_data = req_data[grant_id_q*DATA_WIDTH +: DATA_WIDTH];
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = grant_vld & (grant_id_q == ID_W'(i)) & ~fifo_full;
    end
  end

  assign xfer = fifo_wr_en;

`ifdef FIFO_ARB_BURST_LOCK_EN
  assign at_limit = (beat_cnt_q == BC_W'(BURST_LEN - 1));
`else
  assign at_limit = 1'b1;
`endif

  // A full FIFO blocks xfer, so it can never trigger a release.
  assign release_g = ~cur_valid | (xfer & at_limit);

  // Next grant: pick in IDLE or on release; pick and release share a cycle.
  always_comb begin
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
`ifdef FIFO_ARB_BURST_LOCK_EN
    beat_cnt_d   = beat_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d      = GRANT;
          grant_id_d   = pick_idx;
          last_grant_d = pick_idx;
`ifdef FIFO_ARB_BURST_LOCK_EN
          beat_cnt_d   = '0;
`endif
        end
      end
      GRANT: begin
        if (release_g) begin
          if (pick_found) begin
            grant_id_d   = pick_idx;
            last_grant_d = pick_idx;
`ifdef FIFO_ARB_BURST_LOCK_EN
            beat_cnt_d   = '0;
`endif
          end else begin
            state_d = IDLE;
          end
        end
`ifdef FIFO_ARB_BURST_LOCK_EN
        else if (xfer) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant state register; last_grant resets to the top index so requester 0 goes first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_id_q   <= '0;
      last_grant_q <= ID_W'(NUM_REQ - 1);
`ifdef FIFO_ARB_BURST_LOCK_EN
      beat_cnt_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
`ifdef FIFO_ARB_BURST_LOCK_EN
      beat_cnt_q   <= beat_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (NUM_REQ=4, DATA_WIDTH=32, BURST_LEN=4).
// Burst-lock cases are compiled when FIFO_ARB_BURST_LOCK_EN is defined.
module tb_fifo_wr_arbiter;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic         fifo_full;
  logic         fifo_wr_en;
  logic [31:0]  fifo_wr_data;
  logic         grant_vld;
  logic [1:0]   grant_id;

  logic [31:0]  pd [4];
  int           n_tests;
  int           n_fail;
  int           wr_cnt;

  assign req_data = {pd[3], pd[2], pd[1], pd[0]};

  fifo_wr_arbiter #(
    .NUM_REQ    (4),
    .DATA_WIDTH (32),
    .BURST_LEN  (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .grant_vld    (grant_vld),
    .grant_id     (grant_id)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reset with the given valids, release just after an edge: caller is in cycle 0.
  task automatic apply_reset(input logic [3:0] v);
    rst_n     = 1'b0;
    req_valid = v;
    fifo_full = 1'b0;
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] rr_seq [6];
    n_tests   = 0;
    n_fail    = 0;
    wr_cnt    = 0;
    rst_n     = 1'b1;
    req_valid = 4'h0;
    fifo_full = 1'b0;
    for (int i = 0; i < 4; i++) pd[i] = 32'h0;

    // Reset held low with every producer valid
    #2;
    rst_n     = 1'b0;
    req_valid = 4'hF;
    #1;
    chk("rst_gv",    {63'd0, grant_vld},  64'd0);
    chk("rst_ready", {60'd0, req_ready},  64'd0);
    chk("rst_wren",  {63'd0, fifo_wr_en}, 64'd0);
    chk("rst_gid",   {62'd0, grant_id},   64'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gv_clk",    {63'd0, grant_vld}, 64'd0);
    chk("rst_ready_clk", {60'd0, req_ready}, 64'd0);

    // Single producer 2 streaming A0, A1, A2
    req_valid = 4'h0;
    rst_n     = 1'b1;
    pd[2]     = 32'hA0;
    req_valid = 4'b0100;
    #1;
    chk("sp_c0_gv",   {63'd0, grant_vld},  64'd0);
    chk("sp_c0_wren", {63'd0, fifo_wr_en}, 64'd0);
    cyc();
    #1;
    chk("sp_c1_gv",    {63'd0, grant_vld},  64'd1);
    chk("sp_c1_gid",   {62'd0, grant_id},   64'd2);
    chk("sp_c1_wren",  {63'd0, fifo_wr_en}, 64'd1);
    chk("sp_c1_data",  {32'd0, fifo_wr_data}, 64'hA0);
    chk("sp_c1_ready", {60'd0, req_ready},  64'b0100);
    cyc();
    pd[2] = 32'hA1;
    #1;
    chk("sp_c2_gid",  {62'd0, grant_id},   64'd2);
    chk("sp_c2_wren", {63'd0, fifo_wr_en}, 64'd1);
    chk("sp_c2_data", {32'd0, fifo_wr_data}, 64'hA1);
    cyc();
    pd[2] = 32'hA2;
    #1;
    chk("sp_c3_gid",  {62'd0, grant_id},   64'd2);
    chk("sp_c3_wren", {63'd0, fifo_wr_en}, 64'd1);
    chk("sp_c3_data", {32'd0, fifo_wr_data}, 64'hA2);
    cyc();
    req_valid = 4'h0;
    #1;
    chk("sp_drop_gv",   {63'd0, grant_vld},  64'd1);
    chk("sp_drop_wren", {63'd0, fifo_wr_en}, 64'd0);
    cyc();
    #1;
    chk("sp_idle_gv", {63'd0, grant_vld}, 64'd0);

`ifndef FIFO_ARB_BURST_LOCK_EN
    // Four producers continuously valid: strict per-beat round robin
    for (int i = 0; i < 4; i++) pd[i] = 32'hB0 + i;
    rr_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    apply_reset(4'hF);
    #1;
    chk("rr_c0_gv",   {63'd0, grant_vld},  64'd0);
    chk("rr_c0_wren", {63'd0, fifo_wr_en}, 64'd0);
    for (int k = 0; k < 6; k++) begin
      cyc();
      #1;
      chk($sformatf("rr_gid%0d", k),  {62'd0, grant_id},     {62'd0, rr_seq[k]});
      chk($sformatf("rr_wren%0d", k), {63'd0, fifo_wr_en},   64'd1);
      chk($sformatf("rr_data%0d", k), {32'd0, fifo_wr_data}, 64'hB0 + 64'(rr_seq[k]));
    end
`endif

    // FIFO full for three cycles while producer 1 holds 0x11
    pd[1] = 32'h11;
    apply_reset(4'b0010);
    #1;
    chk("full_c0_gv", {63'd0, grant_vld}, 64'd0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      fifo_full = 1'b1;
      #1;
      if (fifo_wr_en) wr_cnt++;
      chk($sformatf("full_gid%0d", k),   {62'd0, grant_id},   64'd1);
      chk($sformatf("full_ready%0d", k), {60'd0, req_ready},  64'd0);
      chk($sformatf("full_wren%0d", k),  {63'd0, fifo_wr_en}, 64'd0);
    end
    cyc();
    fifo_full = 1'b0;
    #1;
    if (fifo_wr_en) wr_cnt++;
    chk("full_clr_wren",  {63'd0, fifo_wr_en},   64'd1);
    chk("full_clr_data",  {32'd0, fifo_wr_data}, 64'h11);
    chk("full_clr_ready", {60'd0, req_ready},    64'b0010);
    cyc();
    req_valid = 4'h0;
    #1;
    if (fifo_wr_en) wr_cnt++;
    chk("full_wr_count", 64'(wr_cnt), 64'd1);

    // Asynchronous reset in the middle of producer 3's grant
    pd[3] = 32'h33;
    apply_reset(4'b1000);
    cyc();
    cyc();
    cyc();
    #1;
    chk("ar_pre_gid",  {62'd0, grant_id},   64'd3);
    chk("ar_pre_wren", {63'd0, fifo_wr_en}, 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_gv",    {63'd0, grant_vld},  64'd0);
    chk("ar_wren",  {63'd0, fifo_wr_en}, 64'd0);
    chk("ar_ready", {60'd0, req_ready},  64'd0);
    req_valid = 4'hF;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("ar_c0_gv", {63'd0, grant_vld}, 64'd0);
    cyc();
    #1;
    chk("ar_c1_gv",  {63'd0, grant_vld}, 64'd1);
    chk("ar_c1_gid", {62'd0, grant_id},  64'd0);

`ifdef FIFO_ARB_BURST_LOCK_EN
    // All valid: four beats from producer 0, then four from producer 1
    apply_reset(4'hF);
    for (int k = 0; k < 8; k++) begin
      cyc();
      #1;
      chk($sformatf("bl_gid%0d", k),  {62'd0, grant_id},   (k < 4) ? 64'd0 : 64'd1);
      chk($sformatf("bl_wren%0d", k), {63'd0, fifo_wr_en}, 64'd1);
    end

    // Producer 0 drops valid after two beats; grant passes to producer 1
    apply_reset(4'hF);
    cyc();
    #1;
    chk("bd_c1_gid", {62'd0, grant_id}, 64'd0);
    cyc();
    #1;
    chk("bd_c2_gid", {62'd0, grant_id}, 64'd0);
    cyc();
    req_valid = 4'b1110;
    #1;
    chk("bd_c3_gv",   {63'd0, grant_vld},  64'd1);
    chk("bd_c3_gid",  {62'd0, grant_id},   64'd0);
    chk("bd_c3_wren", {63'd0, fifo_wr_en}, 64'd0);
    cyc();
    req_valid = 4'hF;
    #1;
    chk("bd_c4_gid",  {62'd0, grant_id},   64'd1);
    chk("bd_c4_wren", {63'd0, fifo_wr_en}, 64'd1);
    for (int k = 5; k < 8; k++) begin
      cyc();
      #1;
      chk($sformatf("bd_c%0d_gid", k), {62'd0, grant_id}, 64'd1);
    end
    cyc();
    #1;
    chk("bd_c8_gid", {62'd0, grant_id}, 64'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
